// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Word-organised data memory for a simple CPU core. It accepts one load or
// store at a time, waits a fixed number of wait states, then answers with a
// one-cycle ready pulse.
//
// Handshake: the request is taken only when the responder is idle (busy=0)
// and req=1 at a rising edge; addr/we/wdata are captured on that edge. The
// response is the single cycle in which ready=1. err and rdata are
// meaningful only in that cycle, and rdata then holds until the next
// response. req is ignored while busy=1.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 4..1024)
//   WAIT_CYCLES  wait states before each response (0..15)
//
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset (array contents are kept)
//   req    in   access request, sampled only while idle
//   we     in   1 = write, 0 = read
//   addr   in   byte address
//   wdata  in   store data
//   rdata  out  load data (32'h0 after an illegal access)
//   ready  out  one-cycle response pulse
//   err    out  illegal access flag, only ever high together with ready
//   busy   out  high whenever an access is in flight
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;

   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH];

   logic          accept;
   logic          enter_resp;
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic          illegal;
   logic [AW-1:0] word_idx;

   // With zero wait states the response is entered on the acceptance edge
   // itself, before the latched copies exist, so the live inputs are used
   // while idle and the latched copies otherwise.
   always_comb begin
      accept     = (state == IDLE) && req;
      enter_resp = (state != RESP) && (state_nxt == RESP);
      acc_we     = (state == IDLE) ? we    : we_q;
      acc_addr   = (state == IDLE) ? addr  : addr_q;
      acc_wdata  = (state == IDLE) ? wdata : wdata_q;
      illegal    = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);
      word_idx   = acc_addr[AW+1:2];
   end

   // State register, wait counter, request latches and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= 1'b0;
         if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 4'(WAIT_CYCLES);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            if (illegal) begin
               rdata_q <= 32'd0;
               err_q   <= 1'b1;
            end else if (!acc_we) begin
               rdata_q <= mem[word_idx];
            end
         end
      end
   end

   // Storage array: never cleared by reset, and a write is blocked by a
   // reset arriving on the same edge.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && !illegal && acc_we) begin
         mem[word_idx] <= acc_wdata;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req) begin
               state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt <= 4'd1) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      ready = (state == RESP);
      busy  = (state != IDLE);
      err   = err_q && (state == RESP);
      rdata = rdata_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responder instances with different geometries share one clock and
// reset:
//   0: DEPTH=256, WAIT_CYCLES=2
//   1: DEPTH=16,  WAIT_CYCLES=0
//   2: DEPTH=4,   WAIT_CYCLES=15
// A reference model (word store keyed by instance and word number, plus the
// last returned load value) predicts every response.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_v   [3];
   logic        we_v    [3];
   logic [31:0] addr_v  [3];
   logic [31:0] wdata_v [3];
   logic [31:0] rdata_v [3];
   logic        ready_v [3];
   logic        err_v   [3];
   logic        busy_v  [3];

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl_mem [int];
   logic [31:0] last_rd [3];

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUTs
   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
      .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]),
      .err(err_v[0]), .busy(busy_v[0]));

   dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
      .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]),
      .err(err_v[1]), .busy(busy_v[1]));

   dmem_responder #(.DEPTH(4), .WAIT_CYCLES(15)) dut2 (
      .clk(clk), .rst(rst), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
      .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]),
      .err(err_v[2]), .busy(busy_v[2]));

   // ---------------------------------------------------------------- helpers
   function automatic int depth_of(int d);
      case (d)
         0:       return 256;
         1:       return 16;
         default: return 4;
      endcase
   endfunction

   function automatic int wait_of(int d);
      case (d)
         0:       return 2;
         1:       return 0;
         default: return 15;
      endcase
   endfunction

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: legality from byte-address arithmetic, word store
   // keyed by instance, and the load value the response should carry.
   task automatic model_access(input int d, input bit w, input logic [31:0] a,
                               input logic [31:0] wd, output bit ill,
                               output logic [31:0] exp_rd);
      int dep = depth_of(d);
      int key;
      ill = ((a % 32'd4) != 32'd0) || (a >= 32'(dep * 4));
      key = d * 4096 + int'(a / 32'd4);
      if (ill) begin
         exp_rd = 32'd0;
      end else if (w) begin
         mdl_mem[key] = wd;
         exp_rd = last_rd[d];
      end else if (mdl_mem.exists(key)) begin
         exp_rd = mdl_mem[key];
      end else begin
         exp_rd = 32'hxxxx_xxxx;
      end
      last_rd[d] = exp_rd;
   endtask

   task automatic drive_idle(int d);
      req_v[d]   = 1'b0;
      we_v[d]    = 1'b0;
      addr_v[d]  = 32'd0;
      wdata_v[d] = 32'd0;
   endtask

   // Called at a falling edge while instance d is idle; returns at the falling
   // edge of the first idle cycle after the response.
   task automatic do_access(int d, bit w, logic [31:0] a, logic [31:0] wd, string tag);
      int          wc = wait_of(d);
      bit          ill;
      logic [31:0] prev_rd = last_rd[d];
      logic [31:0] exp_rd;
      chk1({tag, "_busy_before"}, busy_v[d], 1'b0);
      req_v[d]   = 1'b1;
      we_v[d]    = w;
      addr_v[d]  = a;
      wdata_v[d] = wd;
      model_access(d, w, a, wd, ill, exp_rd);
      @(posedge clk);
      #1;
      // Scramble the inputs: the in-flight access must use its latched copy.
      req_v[d]   = 1'b0;
      we_v[d]    = 1'($urandom);
      addr_v[d]  = $urandom;
      wdata_v[d] = $urandom;
      for (int k = 1; k <= wc + 1; k++) begin
         @(negedge clk);
         chk1($sformatf("%s_ready_c%0d", tag, k), ready_v[d], k == wc + 1);
         chk1($sformatf("%s_busy_c%0d", tag, k), busy_v[d], 1'b1);
         chk1($sformatf("%s_err_c%0d", tag, k), err_v[d], (k == wc + 1) ? ill : 1'b0);
         if (k == wc + 1) chk32({tag, "_rdata"}, rdata_v[d], exp_rd);
         else             chk32($sformatf("%s_rdata_hold_c%0d", tag, k), rdata_v[d], prev_rd);
      end
      drive_idle(d);
      @(negedge clk);
      chk1({tag, "_ready_after"}, ready_v[d], 1'b0);
      chk1({tag, "_busy_after"}, busy_v[d], 1'b0);
      chk1({tag, "_err_after"}, err_v[d], 1'b0);
      chk32({tag, "_rdata_after"}, rdata_v[d], exp_rd);
   endtask

   // Pulse reset for one edge, starting and ending at a falling edge.
   task automatic pulse_reset(string tag);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         last_rd[d] = 32'd0;
         chk1($sformatf("%s_ready%0d", tag, d), ready_v[d], 1'b0);
         chk1($sformatf("%s_busy%0d", tag, d), busy_v[d], 1'b0);
         chk1($sformatf("%s_err%0d", tag, d), err_v[d], 1'b0);
         chk32($sformatf("%s_rdata%0d", tag, d), rdata_v[d], 32'd0);
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      bit          ill;
      logic [31:0] exp_rd;
      logic [31:0] a;
      bit          w;
      int          r, dep, aw, word, key;

      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         drive_idle(d);
         last_rd[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      pulse_reset("reset");

      // Write then read back with two wait states.
      do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
      do_access(0, 1'b0, 32'h10, 32'h0, "rd10");

      // Misaligned and out-of-range accesses leave the array alone; 0x400
      // would alias to word 0 if the range check were missing.
      do_access(0, 1'b1, 32'h0, 32'hA5A5_0000, "wr00");
      do_access(0, 1'b1, 32'h100, 32'hCAFE_F00D, "wr100");
      do_access(0, 1'b0, 32'h13, 32'h0, "rd13_misal");
      do_access(0, 1'b1, 32'h400, 32'h1111_2222, "wr400_oor");
      do_access(0, 1'b1, 32'h102, 32'h3333_4444, "wr102_misal");
      do_access(0, 1'b0, 32'h100, 32'h0, "rd100");
      do_access(0, 1'b0, 32'h0, 32'h0, "rd00");

      // Reset in the first wait cycle aborts a pending write; the read that
      // follows is accepted on the first edge after reset is released.
      do_access(0, 1'b1, 32'h20, 32'h0BAD_0BAD, "wr20_prior");
      req_v[0]   = 1'b1;
      we_v[0]    = 1'b1;
      addr_v[0]  = 32'h20;
      wdata_v[0] = 32'h12345678;
      @(posedge clk);
      #1;
      drive_idle(0);
      @(negedge clk);
      chk1("abort_busy_wait", busy_v[0], 1'b1);
      pulse_reset("abort_rst");
      do_access(0, 1'b0, 32'h20, 32'h0, "rd20_after_abort");

      // Zero wait states with req held high: one response every second cycle.
      for (int i = 0; i < 8; i++) begin
         chk1($sformatf("b2b_idle_ready%0d", i), ready_v[1], 1'b0);
         chk1($sformatf("b2b_idle_busy%0d", i), busy_v[1], 1'b0);
         w = (i < 4);
         a = 32'((i % 4) * 4);
         req_v[1]   = 1'b1;
         we_v[1]    = w;
         addr_v[1]  = a;
         wdata_v[1] = $urandom;
         model_access(1, w, a, wdata_v[1], ill, exp_rd);
         @(posedge clk);
         #1;
         we_v[1]    = 1'($urandom);
         addr_v[1]  = $urandom;
         wdata_v[1] = $urandom;
         @(negedge clk);
         chk1($sformatf("b2b_ready%0d", i), ready_v[1], 1'b1);
         chk1($sformatf("b2b_busy%0d", i), busy_v[1], 1'b1);
         chk1($sformatf("b2b_err%0d", i), err_v[1], ill);
         chk32($sformatf("b2b_rdata%0d", i), rdata_v[1], exp_rd);
         @(negedge clk);
      end
      drive_idle(1);
      @(negedge clk);
      chk1("b2b_end_busy", busy_v[1], 1'b0);

      // Fifteen wait states.
      do_access(2, 1'b1, 32'h8, 32'h5A5A_5A5A, "w15_wr");
      do_access(2, 1'b0, 32'h8, 32'h0, "w15_rd");
      do_access(2, 1'b0, 32'h10, 32'h0, "w15_oor");

      // Randomised accesses on every instance.
      for (int d = 0; d < 3; d++) begin
         dep = depth_of(d);
         aw  = $clog2(dep);
         for (int n = 0; n < 20; n++) begin
            r    = $urandom_range(0, 9);
            word = $urandom_range(0, dep - 1);
            key  = d * 4096 + word;
            a    = 32'(word * 4);
            if (r < 2) begin
               a = a | 32'($urandom_range(1, 3));
               w = 1'($urandom);
            end else if (r < 3) begin
               a = a | (32'h1 << $urandom_range(aw + 2, 31));
               w = 1'($urandom);
            end else begin
               w = ($urandom_range(0, 1) == 1) || !mdl_mem.exists(key);
            end
            do_access(d, w, a, $urandom, $sformatf("rnd%0d_%0d", d, n));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
